// File: rtl/moving_snake_core.sv
// Snake body position engine: a shift register of grid cells advanced one
// cell every STEP_DIV clocks, with a combinational cell-occupancy query port.
module moving_snake_core #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 64,
  parameter int STEP_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] di,
  input  logic [6:0] len,
  input  logic [4:0] qx,
  input  logic [4:0] qy,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic [1:0] dir,
  output logic       step,
  output logic       occupied,
  output logic       self_hit
);

  localparam int            CW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [4:0]    X_MAX    = 5'(GRID_W - 1);
  localparam logic [4:0]    Y_MAX    = 5'(GRID_H - 1);
  localparam logic [4:0]    X_MID    = 5'(GRID_W / 2);
  localparam logic [4:0]    Y_MID    = 5'(GRID_H / 2);
  localparam logic [6:0]    LEN_MAX  = 7'(MAX_LEN);

  logic [4:0]    seg_x [MAX_LEN];
  logic [4:0]    seg_y [MAX_LEN];
  logic [CW-1:0] cnt;
  logic [1:0]    new_dir;
  logic [4:0]    nx;
  logic [4:0]    ny;
  logic [6:0]    len_eff;

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

  // di is only meaningful on the wrap cycle; a reversal request keeps dir.
  // Reverse pairs (0,1) and (2,3) are exactly the codes whose XOR is 01.
  always_comb begin
    new_dir = ((dir ^ di) == 2'b01) ? dir : di;
  end

  always_comb begin
    nx = seg_x[0];
    ny = seg_y[0];
    case (new_dir)
      2'd0: ny = (seg_y[0] == 5'd0)  ? Y_MAX : seg_y[0] - 5'd1;
      2'd1: ny = (seg_y[0] == Y_MAX) ? 5'd0  : seg_y[0] + 5'd1;
      2'd2: nx = (seg_x[0] == 5'd0)  ? X_MAX : seg_x[0] - 5'd1;
      default: nx = (seg_x[0] == X_MAX) ? 5'd0 : seg_x[0] + 5'd1;
    endcase
  end

  always_comb begin
    if (len == 7'd0)         len_eff = 7'd1;
    else if (len > LEN_MAX)  len_eff = LEN_MAX;
    else                     len_eff = len;
  end

  // Storage beyond len_eff is kept (it is the trail revealed on growth)
  // but never takes part in queries.
  always_comb begin
    occupied = 1'b0;
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len_eff)) begin
        if (seg_x[i] == qx && seg_y[i] == qy) occupied = 1'b1;
        if (i > 0 && seg_x[i] == seg_x[0] && seg_y[i] == seg_y[0]) self_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= X_MID;
        seg_y[i] <= Y_MID;
      end
      dir  <= 2'd3;
      cnt  <= '0;
      step <= 1'b0;
    end else begin
      step <= 1'b0;
      if (cnt == CNT_LAST) begin
        cnt      <= '0;
        step     <= 1'b1;
        dir      <= new_dir;
        seg_x[0] <= nx;
        seg_y[0] <= ny;
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_moving_snake_core.sv
// Directed bench for moving_snake_core with STEP_DIV=4, MAX_LEN=8: a vector
// table for stepping and queries plus hand sequences for wrap, hit and reset.
module tb_moving_snake_core;

  logic       clk;
  logic       rst_n;
  logic [1:0] di;
  logic [6:0] len;
  logic [4:0] qx;
  logic [4:0] qy;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir;
  logic       step;
  logic       occupied;
  logic       self_hit;

  int total;
  int passed;

  moving_snake_core #(
    .GRID_W(32), .GRID_H(24), .MAX_LEN(8), .STEP_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .di(di), .len(len), .qx(qx), .qy(qy),
    .head_x(head_x), .head_y(head_y), .dir(dir), .step(step),
    .occupied(occupied), .self_hit(self_hit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         adv;
    logic [1:0] di;
    logic [6:0] len;
    logic [4:0] qx;
    logic [4:0] qy;
    logic [4:0] hx;
    logic [4:0] hy;
    logic [1:0] dir;
    logic       occ;
    logic       hit;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Waits on negedges until step is seen; returns how many negedges it took.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 16);
    if (!step) check("step_timeout", 0, 1);
  endtask

  task automatic step_n(input logic [1:0] d, input int k);
    int n;
    di = d;
    for (int s = 0; s < k; s++) wait_step(n);
  endtask

  initial begin
    int n;
    total  = 0;
    passed = 0;

    vecs[0]  = '{1'b1, 2'd3, 7'd3,   5'd18, 5'd12, 5'd17, 5'd12, 2'd3, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd3, 7'd3,   5'd16, 5'd12, 5'd18, 5'd12, 2'd3, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 2'd3, 7'd3,   5'd18, 5'd12, 5'd19, 5'd12, 2'd3, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 7'd3,   5'd17, 5'd12, 5'd19, 5'd12, 2'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 2'd3, 7'd3,   5'd16, 5'd12, 5'd19, 5'd12, 2'd3, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 2'd2, 7'd3,   5'd19, 5'd12, 5'd20, 5'd12, 2'd3, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 7'd3,   5'd20, 5'd12, 5'd20, 5'd11, 2'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 7'd3,   5'd19, 5'd12, 5'd20, 5'd10, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'd1, 7'd0,   5'd20, 5'd10, 5'd20, 5'd10, 2'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 7'd0,   5'd20, 5'd11, 5'd20, 5'd10, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'd1, 7'd6,   5'd18, 5'd12, 5'd20, 5'd10, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 2'd1, 7'd100, 5'd16, 5'd12, 5'd20, 5'd10, 2'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 2'd1, 7'd7,   5'd16, 5'd12, 5'd20, 5'd10, 2'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 2'd1, 7'd6,   5'd16, 5'd12, 5'd20, 5'd10, 2'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    di    = 2'd3;
    len   = 7'd3;
    qx    = 5'd16;
    qy    = 5'd12;
    #23;
    check("rst_head_x", head_x, 16);
    check("rst_head_y", head_y, 12);
    check("rst_dir", dir, 3);
    check("rst_step", step, 0);
    check("rst_occ", occupied, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven stepping and queries
    for (int v = 0; v < 14; v++) begin
      di  = vecs[v].di;
      len = vecs[v].len;
      qx  = vecs[v].qx;
      qy  = vecs[v].qy;
      if (vecs[v].adv) begin
        wait_step(n);
        check($sformatf("v%0d_gap", v), n, 4);
      end else begin
        #1;
      end
      check($sformatf("v%0d_hx", v), head_x, vecs[v].hx);
      check($sformatf("v%0d_hy", v), head_y, vecs[v].hy);
      check($sformatf("v%0d_dir", v), dir, vecs[v].dir);
      check($sformatf("v%0d_occ", v), occupied, vecs[v].occ);
      check($sformatf("v%0d_hit", v), self_hit, vecs[v].hit);
    end

    // wrap right: head (20,10) -> 11 steps to (31,10) -> (0,10)
    len = 7'd1;
    step_n(2'd3, 11);
    check("wrap_r_pre_x", head_x, 31);
    step_n(2'd3, 1);
    check("wrap_r_x", head_x, 0);
    check("wrap_r_y", head_y, 10);
    // wrap up: 10 steps to y=0, one more to y=23
    step_n(2'd0, 10);
    check("wrap_u_pre_y", head_y, 0);
    step_n(2'd0, 1);
    check("wrap_u_y", head_y, 23);
    check("wrap_u_x", head_x, 0);
    // wrap left from x=0
    step_n(2'd2, 1);
    check("wrap_l_x", head_x, 31);
    check("wrap_l_y", head_y, 23);
    check("wrap_l_dir", dir, 2);

    // asynchronous reset between clock edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_head_x", head_x, 16);
    check("arst_head_y", head_y, 12);
    check("arst_dir", dir, 3);
    check("arst_step", step, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // self-hit: lay body right, then down, left, up back onto segment 4
    len = 7'd5;
    step_n(2'd3, 4);
    check("sh_right_hx", head_x, 20);
    check("sh_right_hit", self_hit, 0);
    step_n(2'd1, 1);
    check("sh_down_hit", self_hit, 0);
    step_n(2'd2, 1);
    check("sh_left_hit", self_hit, 0);
    step_n(2'd0, 1);
    check("sh_up_hx", head_x, 19);
    check("sh_up_hy", head_y, 12);
    check("sh_up_hit", self_hit, 1);
    len = 7'd4;
    #1;
    check("sh_len4_hit", self_hit, 0);
    len = 7'd1;
    #1;
    check("sh_len1_hit", self_hit, 0);
    @(negedge clk);
    check("step_width", step, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
